// File: rtl/safer_eval_scheduler.sv
// Shares one risk-evaluation engine among four SAFER domain requesters:
// critical-first round-robin arbitration, valid/ready issue, watchdog on the result.
module safer_eval_scheduler #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [3:0]            req_crit,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            gnt,
  output logic                  eng_valid,
  input  logic                  eng_ready,
  output logic [1:0]            eng_id,
  output logic [DATA_W-1:0]     eng_data,
  input  logic                  res_valid,
  input  logic [DATA_W-1:0]     res_score,
  output logic [3:0]            done,
  output logic [DATA_W-1:0]     done_score,
  output logic [3:0]            err_flags,
  input  logic                  err_clr,
  output logic                  busy
);

  localparam int unsigned NREQ = 4;
  localparam int unsigned TW   = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        rr_q, rr_d;
  logic [1:0]        id_q, id_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        gnt_q, gnt_d;
  logic              eng_valid_q, eng_valid_d;
  logic [3:0]        done_q, done_d;
  logic [DATA_W-1:0] score_q, score_d;
  logic [3:0]        err_q, err_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] req_ops [NREQ];
  logic [3:0]        eff_req;
  logic [1:0]        arb_idx;
  logic [1:0]        win_id;
  logic              win_found;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ops[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Critical requests mask everything else; search upward from rr_q, nearest offset wins.
  always_comb begin
    eff_req   = ((req & req_crit) != 4'b0) ? (req & req_crit) : req;
    win_found = 1'b0;
    win_id    = rr_q;
    arb_idx   = rr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      arb_idx = rr_q + 2'(i);
      if (eff_req[arb_idx]) begin
        win_found = 1'b1;
        win_id    = arb_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    data_d      = data_q;
    gnt_d       = 4'b0;
    eng_valid_d = eng_valid_q;
    done_d      = 4'b0;
    score_d     = score_q;
    err_d       = err_clr ? 4'b0 : err_q;
    timer_d     = timer_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          id_d        = win_id;
          data_d      = req_ops[win_id];
          gnt_d       = 4'b0001 << win_id;
          eng_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (eng_valid_q && eng_ready) begin
          timer_d     = '0;
          eng_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // A result arriving on the expiry cycle still completes normally.
        if (res_valid) begin
          score_d = res_score;
          done_d  = 4'b0001 << id_q;
          state_d = S_DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d[id_q] = 1'b1;
          rr_d        = id_q + 2'd1;
          state_d     = S_IDLE;
        end
      end
      S_DONE: begin
        rr_d    = id_q + 2'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 2'd0;
      id_q        <= 2'd0;
      data_q      <= '0;
      gnt_q       <= 4'b0;
      eng_valid_q <= 1'b0;
      done_q      <= 4'b0;
      score_q     <= '0;
      err_q       <= 4'b0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      data_q      <= data_d;
      gnt_q       <= gnt_d;
      eng_valid_q <= eng_valid_d;
      done_q      <= done_d;
      score_q     <= score_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign eng_valid  = eng_valid_q;
  assign eng_id     = id_q;
  assign eng_data   = data_q;
  assign done       = done_q;
  assign done_score = score_q;
  assign err_flags  = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_safer_eval_scheduler.sv
// Directed self-checking bench for safer_eval_scheduler (DATA_W=16, TIMEOUT=64).
module tb_safer_eval_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  req_crit;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic        eng_valid;
  logic        eng_ready;
  logic [1:0]  eng_id;
  logic [15:0] eng_data;
  logic        res_valid;
  logic [15:0] res_score;
  logic [3:0]  done;
  logic [15:0] done_score;
  logic [3:0]  err_flags;
  logic        err_clr;
  logic        busy;

  int n_checks = 0;
  int n_errs   = 0;
  logic [15:0] ops [4];
  logic any_done;

  safer_eval_scheduler #(.DATA_W(16), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_crit   (req_crit),
    .req_data   (req_data),
    .gnt        (gnt),
    .eng_valid  (eng_valid),
    .eng_ready  (eng_ready),
    .eng_id     (eng_id),
    .eng_data   (eng_data),
    .res_valid  (res_valid),
    .res_score  (res_score),
    .done       (done),
    .done_score (done_score),
    .err_flags  (err_flags),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " gnt"}, 32'(gnt), 0);
    check_eq({tag, " eng_valid"}, 32'(eng_valid), 0);
    check_eq({tag, " eng_id"}, 32'(eng_id), 0);
    check_eq({tag, " eng_data"}, 32'(eng_data), 0);
    check_eq({tag, " done"}, 32'(done), 0);
    check_eq({tag, " done_score"}, 32'(done_score), 0);
    check_eq({tag, " err_flags"}, 32'(err_flags), 0);
    check_eq({tag, " busy"}, 32'(busy), 0);
  endtask

  // Grant at N+1, handshake at N+1, result in first WAIT cycle, done at N+3, IDLE at N+4.
  task automatic txn(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_id,
                     input logic [15:0] score);
    step();
    check_eq({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
    check_eq({tag, " eng_valid"}, 32'(eng_valid), 1);
    check_eq({tag, " eng_id"}, 32'(eng_id), 32'(exp_id));
    check_eq({tag, " eng_data"}, 32'(eng_data), 32'(ops[exp_id]));
    check_eq({tag, " busy"}, 32'(busy), 1);
    step();
    check_eq({tag, " wait eng_valid"}, 32'(eng_valid), 0);
    check_eq({tag, " wait gnt"}, 32'(gnt), 0);
    res_valid = 1'b1;
    res_score = score;
    step();
    res_valid = 1'b0;
    check_eq({tag, " done"}, 32'(done), 32'(exp_gnt));
    check_eq({tag, " done_score"}, 32'(done_score), 32'(score));
    step();
    check_eq({tag, " done clear"}, 32'(done), 0);
    check_eq({tag, " idle busy"}, 32'(busy), 0);
  endtask

  initial begin
    ops[0] = 16'h1234;
    ops[1] = 16'h2222;
    ops[2] = 16'h3333;
    ops[3] = 16'h4444;
    req_data  = {ops[3], ops[2], ops[1], ops[0]};
    rst_n     = 1'b0;
    req       = 4'b0;
    req_crit  = 4'b0;
    eng_ready = 1'b1;
    res_valid = 1'b0;
    res_score = 16'h0;
    err_clr   = 1'b0;
    repeat (3) step();
    check_all_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin from rr_ptr=0 with all requests held.
    req = 4'b1111;
    txn("rr0", 4'b0001, 2'd0, 16'h0101);
    txn("rr1", 4'b0010, 2'd1, 16'h0202);
    txn("rr2", 4'b0100, 2'd2, 16'h0303);
    txn("rr3", 4'b1000, 2'd3, 16'h0404);
    txn("rr4", 4'b0001, 2'd0, 16'h0505);

    // Critical override with rr_ptr=1, then rr resumes from 0 (after id 3).
    req_crit = 4'b1000;
    txn("crit", 4'b1000, 2'd3, 16'h0606);
    req_crit = 4'b0000;
    req      = 4'b1110;
    txn("post_crit", 4'b0010, 2'd1, 16'h0707);

    req = 4'b0001;
    txn("single", 4'b0001, 2'd0, 16'hA5A5);

    // Engine stall for 10 cycles in ISSUE.
    req       = 4'b0100;
    eng_ready = 1'b0;
    step();
    req = 4'b0;
    check_eq("stall gnt", 32'(gnt), 32'h4);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("stall eng_valid", 32'(eng_valid), 1);
      check_eq("stall eng_id", 32'(eng_id), 2);
      check_eq("stall eng_data", 32'(eng_data), 32'h3333);
    end
    check_eq("stall err", 32'(err_flags), 0);
    eng_ready = 1'b1;
    step();
    check_eq("stall hs eng_valid", 32'(eng_valid), 0);
    check_eq("stall hs busy", 32'(busy), 1);
    res_valid = 1'b1;
    res_score = 16'h5A5A;
    step();
    res_valid = 1'b0;
    check_eq("stall done", 32'(done), 32'h4);
    check_eq("stall done_score", 32'(done_score), 32'h5A5A);
    step();

    // Timeout on id 3 (rr_ptr=3).
    req = 4'b1000;
    step();
    req = 4'b0;
    check_eq("to1 gnt", 32'(gnt), 32'h8);
    step();
    any_done = 1'b0;
    repeat (63) begin
      step();
      if (done != 4'b0) any_done = 1'b1;
    end
    check_eq("to1 pre busy", 32'(busy), 1);
    check_eq("to1 pre err", 32'(err_flags), 0);
    step();
    if (done != 4'b0) any_done = 1'b1;
    check_eq("to1 err", 32'(err_flags), 32'h8);
    check_eq("to1 busy", 32'(busy), 0);
    check_eq("to1 no done", 32'(any_done), 0);

    // Next requester after timeout is id 0, then a timeout coinciding with err_clr.
    req = 4'b1001;
    step();
    req = 4'b0;
    check_eq("to2 gnt", 32'(gnt), 32'h1);
    step();
    repeat (63) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("to2 clr err", 32'(err_flags), 32'h1);
    check_eq("to2 busy", 32'(busy), 0);

    // Result on the expiry cycle beats the timeout.
    req = 4'b0010;
    step();
    req = 4'b0;
    check_eq("edge gnt", 32'(gnt), 32'h2);
    step();
    repeat (63) step();
    res_valid = 1'b1;
    res_score = 16'h0BEE;
    step();
    res_valid = 1'b0;
    check_eq("edge done", 32'(done), 32'h2);
    check_eq("edge done_score", 32'(done_score), 32'h0BEE);
    check_eq("edge err", 32'(err_flags), 32'h1);
    step();

    // Asynchronous reset mid-WAIT, then a stray result.
    req = 4'b0100;
    step();
    req = 4'b0;
    check_eq("rst gnt", 32'(gnt), 32'h4);
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n     = 1'b1;
    res_valid = 1'b1;
    res_score = 16'hFFFF;
    any_done  = 1'b0;
    repeat (4) begin
      step();
      if (done != 4'b0 || busy) any_done = 1'b1;
    end
    res_valid = 1'b0;
    check_eq("post_rst no done", 32'(any_done), 0);

    // rr_ptr back at 0 after reset.
    req = 4'b1111;
    txn("post_rst rr", 4'b0001, 2'd0, 16'h1111);
    req = 4'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
